hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Per-register in-flight scoreboard for the ID stage; parametrised successor to the fixed 8-reg forwarding logic.
//  Tracks the age of every pending write as a per-register down-counter and drives ID-stage forwarding selects.
//  Detects load-use hazards and raises stall.
//  Sits between decode and the ALU/register-read operand muxes; one instance per issue slot.
// PARAMETERS
//  NREG       8  number of architectural registers
//  RW         3  register index width, RW = $clog2(NREG)
//  NSRC       2  number of source operands checked per instruction
//  DEPTH      3  stages after ID holding forwardable results (1=EX, 2=MEM, 3=WB)
//  LOAD_EXTRA 1  extra cycles before a load result is forwardable (0..DEPTH-1)
//  SW         2  select width, SW = $clog2(DEPTH+1)
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  id_valid     in   1         valid instruction in ID
//  id_wr_en     in   1         instruction in ID writes a register
//  id_rd        in   RW        destination register
//  id_is_load   in   1         instruction in ID is a load
//  id_src       in   NSRC*RW   source register indices, src i at [i*RW +: RW]
//  id_src_used  in   NSRC      bit i: source i is actually read
//  flush        in   1         kill instruction in ID this cycle (branch taken)
//  stall        out  1         hold PC/IF/ID, inject bubble into EX
//  fwd_sel      out  NSRC*SW   per source: 0=regfile, k=result from stage k (1=EX .. DEPTH)
//  pending      out  NREG      bit r: cnt[r] != 0
// BEHAVIOUR
//  - State per register r: cnt[r] in 0..DEPTH and ld[r] (1 bit). Reset: all cnt=0, ld=0.
//    Outputs at reset: stall=0, fwd_sel=0, pending=0.
//  - Combinational from current state and ID inputs; no output register. For source i with index s=src_i:
//      c = cnt[s]; fwd_sel_i = (c==0) ? 0 : DEPTH-c+1.
//      hz_i = id_valid & id_src_used[i] & ld[s] & (c != 0) & (DEPTH-c+1 <= LOAD_EXTRA).
//  - stall = OR of hz_i. Unused sources (id_src_used=0) still report fwd_sel but never stall.
//  - issue = id_valid & id_wr_en & ~stall & ~flush.
//  - Every rising edge, for each r:
//      if issue && r==id_rd: cnt<=DEPTH, ld<=id_is_load
//      elif cnt!=0:          cnt<=cnt-1, ld unchanged; ld<=0 when cnt becomes 0
//      else:                 hold
//  - Counters age during stall: the bubble enters EX, older producers advance. The held instruction re-evaluates next cycle.
//  - Same-cycle rd==src: selects and stall use pre-edge state (the instruction reads the older value).
//  - Overwrite: issuing to a register with a pending write restarts cnt at DEPTH; newest producer wins.
//  - flush: suppresses issue only; existing counters keep aging. flush & stall: flush wins for issue, stall still driven.
//  - Reset asserted mid-operation clears all state immediately (async); first edge after release sees an empty board.
//  - Latency: fwd_sel/stall are valid in the same cycle as ID inputs; scoreboard update takes 1 cycle.
// CONFIGURATION
//  HAZARD_ZERO_REG_EN defined: register 0 is hardwired zero.
//    - Writes to id_rd==0 never update cnt/ld.
//    - Sources reading reg 0 always get fwd_sel=0 and no hazard; pending[0]=0.
//  Not defined: register 0 is tracked like any other register.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> stall=0, pending=0, all fwd_sel=0; async clear checked mid-cycle.
//  2 ALU chain: issue wr r3, then read r3 on cycles +1/+2/+3/+4 -> fwd_sel=1,2,3,0; stall=0 throughout.
//  3 Load-use (LOAD_EXTRA=1): load r2, next instr reads r2 -> stall=1 for exactly 1 cycle,
//    then fwd_sel=2, stall=0; no issue occurs during the stall cycle.
//  4 Overwrite: write r5 (ALU), next cycle write r5 (load), next read r5 -> stall=1 (newest, load), then fwd_sel=2.
//  5 Flush: id_valid=1, wr r4, flush=1 -> pending[4] stays 0; same cycle with stall=1 -> no state change to r4.
//  6 HAZARD_ZERO_REG_EN: write r0, then read r0 next cycle -> fwd_sel=0, pending[0]=0; macro off -> fwd_sel=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight scoreboard: ages pending writes, drives ID forwarding selects and load-use stall.
// Optional build macro HAZARD_ZERO_REG_EN makes register 0 a hardwired zero (never tracked).
module hazard_scoreboard #(
  parameter int NREG       = 8,
  parameter int RW         = 3,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_EXTRA = 1,
  parameter int SW         = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic                 id_wr_en,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_is_load,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [NREG-1:0]      pending
);

  localparam logic [SW:0] DP1 = (SW+1)'(DEPTH + 1);
  localparam logic [SW:0] LX  = (SW+1)'(LOAD_EXTRA);

  logic [SW-1:0] cnt_q [NREG];
  logic [SW-1:0] cnt_d [NREG];
  logic [NREG-1:0] ld_q, ld_d;
  logic issue;

  // ID handshake: an instruction with id_valid is accepted on the edge only when stall is low;
  // flush drops it without stalling, so stall acts as the inverse of ready.
  always_comb begin
    logic [RW-1:0] s;
    logic [SW-1:0] c;
    logic [SW:0]   age;
    logic          zero_src;
    stall   = 1'b0;
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      s   = id_src[i*RW +: RW];
      c   = cnt_q[s];
      age = DP1 - {1'b0, c};
`ifdef HAZARD_ZERO_REG_EN
      zero_src = (s == '0);
`else
      zero_src = 1'b0;
`endif
      if (c != '0 && !zero_src) begin
        fwd_sel[i*SW +: SW] = age[SW-1:0];
        if (id_valid && id_src_used[i] && ld_q[s] && (age <= LX))
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    logic rd_ok;
`ifdef HAZARD_ZERO_REG_EN
    rd_ok = (id_rd != '0);
`else
    rd_ok = 1'b1;
`endif
    issue = id_valid & id_wr_en & ~stall & ~flush & rd_ok;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      ld_d[r]  = ld_q[r];
      if (issue && id_rd == RW'(r)) begin
        cnt_d[r] = SW'(DEPTH);
        ld_d[r]  = id_is_load;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - SW'(1);
        if (cnt_q[r] == SW'(1)) ld_d[r] = 1'b0;
      end
      pending[r] = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      ld_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      ld_q <= ld_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, ALU forwarding chain, load-use, overwrite, flush, register 0.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_wr_en, id_is_load, flush;
  logic [2:0] id_rd;
  logic [5:0] id_src;
  logic [1:0] id_src_used;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [7:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_src(id_src), .id_src_used(id_src_used), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic w, input logic [2:0] rd, input logic ld,
                       input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                       input logic fl);
    id_valid = v; id_wr_en = w; id_rd = rd; id_is_load = ld;
    id_src = {s1, s0}; id_src_used = used; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0);
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1'($urandom_range(0, 1)); id_wr_en = 1'($urandom_range(0, 1));
    id_rd = 3'($urandom_range(0, 7)); id_is_load = 1'($urandom_range(0, 1));
    id_src = 6'($urandom_range(0, 63)); id_src_used = 2'($urandom_range(0, 3));
    flush = 1'($urandom_range(0, 1));
    #2;
    n_tests++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || pending !== 8'd0) begin
      $display("FAIL reset_outputs: stall=%b fwd_sel=%h pending=%h, want 0/0/0", stall, fwd_sel, pending);
      n_fail++;
    end
    drive(1, 1, 3'd3, 1, 3'd3, 3'd3, 2'b11, 0);
    tick();
    n_tests++;
    if (pending !== 8'd0) begin
      $display("FAIL reset_held_edge: pending=%h want 00", pending);
      n_fail++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    drive(1, 1, 3'd3, 0, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 0, 3'd0, 0, 3'd3, 3'd0, 2'b01, 0);
    #1;
    n_tests++;
    if (pending !== 8'h08 || fwd_sel[1:0] !== 2'd1) begin
      $display("FAIL reset_pre_async: pending=%h fwd0=%0d want 08/1", pending, fwd_sel[1:0]);
      n_fail++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (pending !== 8'd0 || fwd_sel !== 4'd0 || stall !== 1'b0) begin
      $display("FAIL reset_async_clear: pending=%h fwd_sel=%h stall=%b want 0", pending, fwd_sel, stall);
      n_fail++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (fwd_sel[1:0] !== 2'd0 || pending !== 8'd0) begin
      $display("FAIL reset_empty_after: fwd0=%0d pending=%h want 0/00", fwd_sel[1:0], pending);
      n_fail++;
    end
    tick();
    drain();
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    drive(1, 1, 3'd3, 0, 3'd0, 3'd0, 2'b00, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 3'd0, 0, 3'd1, 3'd3, 2'b10, 0);
      @(negedge clk);
      n_tests++;
      if (fwd_sel[3:2] !== exp_sel[k] || stall !== 1'b0 || pending[3] !== (k < 3)) begin
        $display("FAIL alu_chain_%0d: fwd1=%0d stall=%b pend3=%b want %0d/0/%b",
                 k + 1, fwd_sel[3:2], stall, pending[3], exp_sel[k], k < 3);
        n_fail++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 1, 3'd2, 1, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 1, 3'd6, 0, 3'd2, 3'd2, 2'b00, 0);
    #1;
    n_tests++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0101) begin
      $display("FAIL load_use_unused: stall=%b fwd_sel=%h want 0/5", stall, fwd_sel);
      n_fail++;
    end
    id_src_used = 2'b01;
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin
      $display("FAIL load_use_stall: stall=%b want 1", stall);
      n_fail++;
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2 || pending[6] !== 1'b0) begin
      $display("FAIL load_use_release: stall=%b fwd0=%0d pend6=%b want 0/2/0", stall, fwd_sel[1:0], pending[6]);
      n_fail++;
    end
    tick();
    drive(0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0);
    @(negedge clk);
    n_tests++;
    if (pending[6] !== 1'b1) begin
      $display("FAIL load_use_issue_after: pend6=%b want 1", pending[6]);
      n_fail++;
    end
    tick();
    drain();
  endtask

  task automatic test_overwrite();
    drive(1, 1, 3'd5, 0, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 1, 3'd5, 1, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 0, 3'd0, 0, 3'd5, 3'd0, 2'b01, 0);
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd1) begin
      $display("FAIL overwrite_stall: stall=%b fwd0=%0d want 1/1", stall, fwd_sel[1:0]);
      n_fail++;
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2) begin
      $display("FAIL overwrite_fwd: stall=%b fwd0=%0d want 0/2", stall, fwd_sel[1:0]);
      n_fail++;
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    drive(1, 1, 3'd4, 0, 3'd0, 3'd0, 2'b00, 1);
    tick();
    drive(0, 0, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0);
    @(negedge clk);
    n_tests++;
    if (pending[4] !== 1'b0) begin
      $display("FAIL flush_no_issue: pend4=%b want 0", pending[4]);
      n_fail++;
    end
    tick();
    drive(1, 1, 3'd1, 1, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 1, 3'd4, 0, 3'd1, 3'd0, 2'b01, 1);
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin
      $display("FAIL flush_stall_driven: stall=%b want 1", stall);
      n_fail++;
    end
    tick();
    drive(1, 0, 3'd0, 0, 3'd1, 3'd0, 2'b00, 0);
    @(negedge clk);
    n_tests++;
    if (pending[4] !== 1'b0 || pending[1] !== 1'b1 || fwd_sel[1:0] !== 2'd2) begin
      $display("FAIL flush_aging: pend4=%b pend1=%b fwd0=%0d want 0/1/2", pending[4], pending[1], fwd_sel[1:0]);
      n_fail++;
    end
    tick();
    drain();
  endtask

  task automatic test_zero_reg();
    logic [1:0] exp_sel;
    logic       exp_pend;
`ifdef HAZARD_ZERO_REG_EN
    exp_sel = 2'd0; exp_pend = 1'b0;
`else
    exp_sel = 2'd1; exp_pend = 1'b1;
`endif
    drive(1, 1, 3'd0, 0, 3'd0, 3'd0, 2'b00, 0);
    tick();
    drive(1, 0, 3'd0, 0, 3'd0, 3'd0, 2'b01, 0);
    @(negedge clk);
    n_tests++;
    if (fwd_sel[1:0] !== exp_sel || pending[0] !== exp_pend) begin
      $display("FAIL zero_reg: fwd0=%0d pend0=%b want %0d/%b", fwd_sel[1:0], pending[0], exp_sel, exp_pend);
      n_fail++;
    end
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_overwrite();
    test_flush();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
